// File: rtl/vga_timing_core.sv
// Raster timing generator: hpos/vpos counters, sync/blank decode, line/frame strobes,
// frame counter with a sticky first-wrap flag, and an optional ce-gated delay line.
module vga_timing_core #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int SYNC_NEG  = 1,
  parameter int PIPE_DLY  = 0,
  parameter int FRAME_W   = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  output logic [9:0]         hpos,
  output logic [9:0]         vpos,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame,
  output logic               frame_wrapped
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS  = 10'(V_DISPLAY);
  localparam logic [9:0] HS_BEG = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  localparam logic       SYNC_ON  = (SYNC_NEG == 0);
  localparam logic       SYNC_OFF = (SYNC_NEG != 0);
  // Packed {hsync, vsync, display_on}; idle value used for reset of every stage.
  localparam logic [2:0] IDLE     = {SYNC_OFF, SYNC_OFF, 1'b0};

  logic [9:0]         h_q, h_d;
  logic [9:0]         v_q, v_d;
  logic [2:0]         raw_q, raw_d;
  logic               ls_q, ls_d;
  logic               fs_q, fs_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               wrapped_q, wrapped_d;

  // Decode is taken from the next counter values so it lands in the same cycle as them.
  always_comb begin
    h_d       = h_q;
    v_d       = v_q;
    raw_d     = raw_q;
    ls_d      = ls_q;
    fs_d      = fs_q;
    frame_d   = frame_q;
    wrapped_d = wrapped_q;
    if (ce) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
      raw_d[2] = (h_d >= HS_BEG && h_d <= HS_END) ? SYNC_ON : SYNC_OFF;
      raw_d[1] = (v_d >= VS_BEG && v_d <= VS_END) ? SYNC_ON : SYNC_OFF;
      raw_d[0] = (h_d < H_VIS) && (v_d < V_VIS);
      ls_d     = (h_d == '0);
      fs_d     = (h_d == '0) && (v_d == '0);
      if (h_q == H_LAST && v_q == V_LAST) begin
        frame_d = frame_q + FRAME_W'(1);
        if (frame_q == '1) wrapped_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q       <= '0;
      v_q       <= '0;
      raw_q     <= IDLE;
      ls_q      <= 1'b0;
      fs_q      <= 1'b0;
      frame_q   <= '0;
      wrapped_q <= 1'b0;
    end else begin
      h_q       <= h_d;
      v_q       <= v_d;
      raw_q     <= raw_d;
      ls_q      <= ls_d;
      fs_q      <= fs_d;
      frame_q   <= frame_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign hpos          = h_q;
  assign vpos          = v_q;
  assign line_start    = ls_q;
  assign frame_start   = fs_q;
  assign frame         = frame_q;
  assign frame_wrapped = wrapped_q;

  generate
    if (PIPE_DLY == 0) begin : g_nodly
      assign {hsync, vsync, display_on} = raw_q;
    end else begin : g_dly
      logic [2:0] pipe_q [PIPE_DLY];
      logic [2:0] pipe_d [PIPE_DLY];

      // The delay line only shifts on ce edges so stalls stretch rather than drop pulses.
      always_comb begin
        pipe_d = pipe_q;
        if (ce) begin
          pipe_d[0] = raw_q;
          for (int i = 1; i < PIPE_DLY; i++) pipe_d[i] = pipe_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < PIPE_DLY; i++) pipe_q[i] <= IDLE;
        end else begin
          pipe_q <= pipe_d;
        end
      end

      assign {hsync, vsync, display_on} = pipe_q[PIPE_DLY-1];
    end
  endgenerate

endmodule
